store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Parametrised successor to the store byte-enable stage. Accepts store requests from the MEM stage, generates lane-aligned write data and byte enables for any power-of-two data width, and queues them in a DEPTH-entry FIFO.
- Drains to the data-memory port through a valid/ready handshake.
- Flags misaligned stores instead of writing them.

Parameters:
- DATA_W, 32, memory data width in bits; power of two, 32 or 64; NB = DATA_W/8 byte lanes, OFS_W = log2(NB).
- ADDR_W, 32, byte-address width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- st_valid  in  1  store request valid.
- st_ready  out  1  buffer can accept; equals !full.
- st_size  in  2  0=byte, 1=half, 2=word, 3=dword (legal only when DATA_W=64).
- st_addr  in  ADDR_W  byte address.
- st_wdata  in  DATA_W  store data, right-justified.
- st_exc  out  1  one-cycle pulse: misaligned or illegal-size store rejected.
- m_valid  out  1  head entry presented.
- m_ready  in  1  memory accepts head.
- m_addr  out  ADDR_W  head address, low OFS_W bits zero.
- m_wdata  out  DATA_W  head lane-aligned data.
- m_byteen  out  NB  head byte enables.
- count  out  log2(DEPTH)+1  occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset: count=0, empty=1, full=0, m_valid=0, st_exc=0, pointers=0. m_addr, m_wdata and m_byteen read 0.
- Size bytes SZ = 1<<st_size. Offset = st_addr[OFS_W-1:0].
- Misaligned when offset mod SZ != 0. Illegal when SZ > NB.
- Byte enables: byteen = ((1<<SZ)-1) << offset, width NB.
- Data: wdata = (st_wdata masked to SZ*8 bits) << (offset*8). Unenabled lanes are zero.
- Push: occurs when st_valid && st_ready && aligned && legal.
  - Entry stores {addr with low OFS_W bits cleared, wdata, byteen}.
  - Entry is visible on m_* at the next cycle at the earliest, so latency is 1.
- Reject: when st_valid && st_ready && (misaligned || illegal), no push occurs. st_exc=1 in the following cycle only. count is unchanged.
- Pop: occurs when m_valid && m_ready. The head advances at the edge.
- m_valid = !empty. m_* are driven from the head entry and hold stable while m_valid && !m_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- When full, st_ready=0 even if a pop happens in the same cycle; there is no full-bypass.
- Pointers wrap modulo DEPTH. count saturates at DEPTH by construction.
- Reset asserted mid-operation: all entries are discarded immediately, including a head being presented.

Optional Feature:
- Macro: STORE_MERGE_EN.
- Defined:
  - A legal incoming store whose aligned address equals the tail entry's address merges into the tail, provided count>=2 (the head is never modified).
  - Merge: byteen |= new byteen. Enabled lanes of the new data overwrite the tail's lanes.
  - count is unchanged. Merging is permitted even when full; st_ready = !full || merge_hit.
- Undefined: no merging, and every legal store occupies a new entry.

Decomposition:
- Package store_buffer_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - the entry struct typedef {addr, wdata, byteen};
  - helper function lane_mask(size, offset).
- Sub-module store_lane_align (purely combinational) produces byteen, aligned wdata and the misalign/illegal flag. The top holds the FIFO and control.

Test Plan:
- Byte store (DATA_W=32): sb addr 0x1003, data 0xAB, m_ready=1 → one cycle later m_addr=0x1000, m_byteen=4'b1000, m_wdata=0xAB000000; popped that cycle.
- Misaligned half store: sh addr 0x1001 → no push, st_exc=1 for exactly one cycle, count stays 0, m_valid stays 0.
- Full/backpressure: m_ready=0, push 4 words (0x0, 0x4, 0x8, 0xC) → full=1, st_ready=0, 5th request held. Then m_ready=1 → drains in order, one per cycle; empty=1 after 4 cycles.
- Simultaneous push and pop at count=2 → count remains 2 and FIFO order is preserved.
- Merge, with m_ready=0: sw 0x2000, then sb 0x2004 0x11, then sb 0x2005 0x22.
  - With STORE_MERGE_EN: count=2, second entry byteen=4'b0011, wdata=0x00002211.
  - Without it: count=3.
- Reset asserted while m_valid=1 and count=3 → asynchronously count=0, m_valid=0, st_ready=1. After release the first new push appears normally.
- DATA_W=64: sd addr 0x08 → byteen=8'hFF. sw addr 0x0C → byteen=8'hF0. sd addr 0x04 → st_exc.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared size encodings, FIFO entry type and lane-mask helper for the store buffer.
// Entry fields are sized for the widest supported configuration; narrower builds use the low bits.
package store_buffer_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  localparam int unsigned MAX_ADDR_W = 64;
  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_NB     = MAX_DATA_W / 8;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
    logic [MAX_NB-1:0]     byteen;
  } sb_entry_t;

  // Byte-lane enables for an access of 1<<size bytes starting at lane offset.
  function automatic logic [MAX_NB-1:0] lane_mask(input logic [1:0] size,
                                                  input logic [2:0] offset);
    logic [MAX_NB-1:0] ones;
    case (size)
      SZ_BYTE: ones = 8'h01;
      SZ_HALF: ones = 8'h03;
      SZ_WORD: ones = 8'h0F;
      default: ones = 8'hFF;
    endcase
    return ones << offset;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store aligner: byte enables, lane-aligned data and the reject flag
// (misaligned offset or a size wider than the data port).
module store_lane_align
  import store_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned NB    = DATA_W / 8,
  localparam int unsigned OFS_W = $clog2(NB)
) (
  input  logic [1:0]        size,
  input  logic [OFS_W-1:0]  offset,
  input  logic [DATA_W-1:0] wdata,
  output logic [NB-1:0]     byteen,
  output logic [DATA_W-1:0] wdata_aligned,
  output logic              bad
);

  logic [2:0]        ofs_ext;
  logic [MAX_NB-1:0] mask_full;
  logic [DATA_W-1:0] lane_bits;
  logic [DATA_W-1:0] shifted;
  logic              misaligned;
  logic              illegal;
  logic              unused_mask_bits;

  assign ofs_ext   = 3'(offset);
  assign mask_full = lane_mask(size, ofs_ext);
  assign byteen    = mask_full[NB-1:0];
  assign unused_mask_bits = ^mask_full;

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = ofs_ext[0];
      SZ_WORD: misaligned = |ofs_ext[1:0];
      default: misaligned = |ofs_ext;
    endcase
  end

  assign illegal = (size == SZ_DWORD) && (NB < 8);
  assign bad     = misaligned | illegal;

  // Shift first, then clear every lane outside the enable mask; this also drops
  // data bits above the access size.
  assign shifted = wdata << {offset, 3'b000};

  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < NB; i++) begin
      lane_bits[i*8 +: 8] = {8{byteen[i]}};
    end
  end

  assign wdata_aligned = shifted & lane_bits;

endmodule

// File: rtl/store_buffer.sv
// Store buffer: aligns MEM-stage stores and queues them in a DEPTH-entry FIFO drained by
// valid/ready. Optional tail merging of same-word stores is enabled by STORE_MERGE_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned NB    = DATA_W / 8,
  localparam int unsigned OFS_W = $clog2(NB),
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_wdata,
  output logic              st_exc,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [NB-1:0]     m_byteen,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  sb_entry_t         mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              exc_q;

  logic [NB-1:0]     new_byteen;
  logic [DATA_W-1:0] new_wdata;
  logic [ADDR_W-1:0] new_addr;
  logic              bad;
  sb_entry_t         new_entry;
  sb_entry_t         head_entry;
  logic              accept, push, pop, reject, merge_hit;
  logic              unused_head_bits;

  store_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size          (st_size),
    .offset        (st_addr[OFS_W-1:0]),
    .wdata         (st_wdata),
    .byteen        (new_byteen),
    .wdata_aligned (new_wdata),
    .bad           (bad)
  );

  assign new_addr = {st_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

  always_comb begin
    new_entry                     = '0;
    new_entry.addr[ADDR_W-1:0]    = new_addr;
    new_entry.wdata[DATA_W-1:0]   = new_wdata;
    new_entry.byteen[NB-1:0]      = new_byteen;
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign accept   = st_valid && st_ready;
  assign reject   = accept && bad;
  assign push     = accept && !bad && !merge_hit;
  assign pop      = m_valid && m_ready;

`ifdef STORE_MERGE_EN
  logic [PTR_W-1:0]      tail_ptr;
  sb_entry_t             tail_entry;
  sb_entry_t             merged_entry;
  logic [MAX_DATA_W-1:0] new_lane_bits;
  logic                  unused_tail_bits;

  assign tail_ptr   = wr_ptr_q - PTR_W'(1);
  assign tail_entry = mem_q[tail_ptr];
  assign unused_tail_bits = ^tail_entry;

  // count >= 2 keeps the head (the entry on m_*) out of reach of a merge.
  assign merge_hit = st_valid && !bad && (count_q >= CNT_W'(2)) &&
                     (tail_entry.addr[ADDR_W-1:0] == new_addr);

  always_comb begin
    new_lane_bits = '0;
    for (int i = 0; i < MAX_NB; i++) begin
      new_lane_bits[i*8 +: 8] = {8{new_entry.byteen[i]}};
    end
    merged_entry        = tail_entry;
    merged_entry.byteen = tail_entry.byteen | new_entry.byteen;
    merged_entry.wdata  = (tail_entry.wdata & ~new_lane_bits) | new_entry.wdata;
  end

  assign st_ready = !full || merge_hit;
`else
  assign merge_hit = 1'b0;
  assign st_ready  = !full;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= new_entry;
      end
`ifdef STORE_MERGE_EN
      if (merge_hit) begin
        mem_q[tail_ptr] <= merged_entry;
      end
`endif
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      exc_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      exc_q   <= reject;
    end
  end

  assign head_entry       = mem_q[rd_ptr_q];
  assign unused_head_bits = ^head_entry;

  assign m_valid  = !empty;
  assign m_addr   = head_entry.addr[ADDR_W-1:0];
  assign m_wdata  = head_entry.wdata[DATA_W-1:0];
  assign m_byteen = head_entry.byteen[NB-1:0];
  assign st_exc   = exc_q;
  assign count    = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: a 32-bit and a 64-bit instance.
module tb_store_buffer;

`ifdef STORE_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic clk;
  logic reset;

  logic        st_valid, st_ready, st_exc, m_valid, m_ready, empty, full;
  logic [1:0]  st_size;
  logic [31:0] st_addr, st_wdata, m_addr, m_wdata;
  logic [3:0]  m_byteen;
  logic [2:0]  count;

  logic        st_valid64, st_ready64, st_exc64, m_valid64, m_ready64, empty64, full64;
  logic [1:0]  st_size64;
  logic [31:0] st_addr64, m_addr64;
  logic [63:0] st_wdata64, m_wdata64;
  logic [7:0]  m_byteen64;
  logic [2:0]  count64;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size), .st_addr(st_addr),
    .st_wdata(st_wdata), .st_exc(st_exc),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_byteen(m_byteen), .count(count), .empty(empty), .full(full)
  );

  store_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
    .clk(clk), .reset(reset),
    .st_valid(st_valid64), .st_ready(st_ready64), .st_size(st_size64),
    .st_addr(st_addr64), .st_wdata(st_wdata64), .st_exc(st_exc64),
    .m_valid(m_valid64), .m_ready(m_ready64), .m_addr(m_addr64), .m_wdata(m_wdata64),
    .m_byteen(m_byteen64), .count(count64), .empty(empty64), .full(full64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    st_valid = 1'b1;
    st_size  = size;
    st_addr  = addr;
    st_wdata = data;
  endtask

  task automatic drive64(input logic [1:0] size, input logic [31:0] addr,
                         input logic [63:0] data);
    st_valid64 = 1'b1;
    st_size64  = size;
    st_addr64  = addr;
    st_wdata64 = data;
  endtask

  initial begin
    reset = 1'b1;
    st_valid = 1'b0; st_size = '0; st_addr = '0; st_wdata = '0; m_ready = 1'b0;
    st_valid64 = 1'b0; st_size64 = '0; st_addr64 = '0; st_wdata64 = '0; m_ready64 = 1'b0;
    step();
    step();

    // Reset state
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_empty", 64'(empty), 64'd1);
    check_eq("rst_full", 64'(full), 64'd0);
    check_eq("rst_m_valid", 64'(m_valid), 64'd0);
    check_eq("rst_st_exc", 64'(st_exc), 64'd0);
    check_eq("rst_st_ready", 64'(st_ready), 64'd1);
    check_eq("rst_m_addr", 64'(m_addr), 64'd0);
    check_eq("rst_m_wdata", 64'(m_wdata), 64'd0);
    check_eq("rst_m_byteen", 64'(m_byteen), 64'd0);
    reset = 1'b0;
    step();

    // Byte store at lane 3, upper data bits must be discarded
    m_ready = 1'b1;
    drive(2'd0, 32'h1003, 32'hFFFF_FFAB);
    step();
    st_valid = 1'b0;
    check_eq("sb_m_valid", 64'(m_valid), 64'd1);
    check_eq("sb_m_addr", 64'(m_addr), 64'h1000);
    check_eq("sb_m_byteen", 64'(m_byteen), 64'h8);
    check_eq("sb_m_wdata", 64'(m_wdata), 64'hAB00_0000);
    step();
    check_eq("sb_popped_empty", 64'(empty), 64'd1);
    check_eq("sb_popped_m_valid", 64'(m_valid), 64'd0);

    // Misaligned half store
    drive(2'd1, 32'h1001, 32'h0000_1234);
    step();
    st_valid = 1'b0;
    check_eq("mis_exc", 64'(st_exc), 64'd1);
    check_eq("mis_count", 64'(count), 64'd0);
    check_eq("mis_m_valid", 64'(m_valid), 64'd0);
    step();
    check_eq("mis_exc_cleared", 64'(st_exc), 64'd0);
    check_eq("mis_count_after", 64'(count), 64'd0);

    // Dword store on a 32-bit port is illegal
    drive(2'd3, 32'h1000, 32'h1);
    step();
    st_valid = 1'b0;
    check_eq("ill_exc", 64'(st_exc), 64'd1);
    check_eq("ill_count", 64'(count), 64'd0);
    step();

    // Fill to full with m_ready low, then drain in order
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(2'd2, 32'(k * 4), 32'h1111_1111 * 32'(k + 1));
      step();
    end
    st_valid = 1'b0;
    check_eq("full_flag", 64'(full), 64'd1);
    check_eq("full_st_ready", 64'(st_ready), 64'd0);
    check_eq("full_count", 64'(count), 64'd4);
    drive(2'd2, 32'h10, 32'h5555_5555);
    step();
    check_eq("full_held_count", 64'(count), 64'd4);
    check_eq("full_held_ready", 64'(st_ready), 64'd0);
    st_valid = 1'b0;
    m_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("drain_addr", 64'(m_addr), 64'(k * 4));
      check_eq("drain_wdata", 64'(m_wdata), 64'(32'h1111_1111 * 32'(k + 1)));
      step();
    end
    check_eq("drain_empty", 64'(empty), 64'd1);
    check_eq("drain_m_valid", 64'(m_valid), 64'd0);

    // Simultaneous push and pop at count 2
    m_ready = 1'b0;
    drive(2'd2, 32'h20, 32'hA0A0_A0A0);
    step();
    drive(2'd2, 32'h24, 32'hB0B0_B0B0);
    step();
    check_eq("pp_count_before", 64'(count), 64'd2);
    drive(2'd2, 32'h28, 32'hC0C0_C0C0);
    m_ready = 1'b1;
    step();
    st_valid = 1'b0;
    check_eq("pp_count", 64'(count), 64'd2);
    check_eq("pp_head1", 64'(m_addr), 64'h24);
    step();
    check_eq("pp_head2", 64'(m_addr), 64'h28);
    check_eq("pp_head2_wdata", 64'(m_wdata), 64'hC0C0_C0C0);
    check_eq("pp_count_after", 64'(count), 64'd1);
    step();
    check_eq("pp_empty", 64'(empty), 64'd1);

    // Same-word stores behind a word store
    m_ready = 1'b0;
    drive(2'd2, 32'h2000, 32'hDEAD_BEEF);
    step();
    drive(2'd0, 32'h2004, 32'h0000_0011);
    step();
    drive(2'd0, 32'h2005, 32'h0000_0022);
    step();
    st_valid = 1'b0;
    check_eq("mrg_count", 64'(count), MERGE ? 64'd2 : 64'd3);
    m_ready = 1'b1;
    check_eq("mrg_e0_addr", 64'(m_addr), 64'h2000);
    check_eq("mrg_e0_byteen", 64'(m_byteen), 64'hF);
    check_eq("mrg_e0_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
    step();
    check_eq("mrg_e1_addr", 64'(m_addr), 64'h2004);
    check_eq("mrg_e1_byteen", 64'(m_byteen), MERGE ? 64'h3 : 64'h1);
    check_eq("mrg_e1_wdata", 64'(m_wdata), MERGE ? 64'h2211 : 64'h11);
    step();
`ifndef STORE_MERGE_EN
    check_eq("mrg_e2_addr", 64'(m_addr), 64'h2004);
    check_eq("mrg_e2_byteen", 64'(m_byteen), 64'h2);
    check_eq("mrg_e2_wdata", 64'(m_wdata), 64'h2200);
    step();
`endif
    check_eq("mrg_empty", 64'(empty), 64'd1);

    // Asynchronous reset while entries are queued
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(2'd2, 32'h30 + 32'(k * 4), 32'h7777_0000 + 32'(k));
      step();
    end
    st_valid = 1'b0;
    check_eq("ar_count_before", 64'(count), 64'd3);
    check_eq("ar_m_valid_before", 64'(m_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_count", 64'(count), 64'd0);
    check_eq("ar_m_valid", 64'(m_valid), 64'd0);
    check_eq("ar_st_ready", 64'(st_ready), 64'd1);
    check_eq("ar_m_addr", 64'(m_addr), 64'd0);
    #1;
    reset = 1'b0;
    step();
    drive(2'd2, 32'h40, 32'hCAFE_F00D);
    m_ready = 1'b1;
    step();
    st_valid = 1'b0;
    check_eq("ar_new_m_valid", 64'(m_valid), 64'd1);
    check_eq("ar_new_addr", 64'(m_addr), 64'h40);
    check_eq("ar_new_wdata", 64'(m_wdata), 64'hCAFE_F00D);
    check_eq("ar_new_count", 64'(count), 64'd1);
    step();
    check_eq("ar_new_empty", 64'(empty), 64'd1);

    // 64-bit data port
    m_ready64 = 1'b1;
    drive64(2'd3, 32'h08, 64'h0123_4567_89AB_CDEF);
    step();
    st_valid64 = 1'b0;
    check_eq("w64_sd_byteen", 64'(m_byteen64), 64'hFF);
    check_eq("w64_sd_addr", 64'(m_addr64), 64'h08);
    check_eq("w64_sd_wdata", m_wdata64, 64'h0123_4567_89AB_CDEF);
    step();
    drive64(2'd2, 32'h0C, 64'hFFFF_FFFF_1234_5678);
    step();
    st_valid64 = 1'b0;
    check_eq("w64_sw_byteen", 64'(m_byteen64), 64'hF0);
    check_eq("w64_sw_addr", 64'(m_addr64), 64'h08);
    check_eq("w64_sw_wdata", m_wdata64, 64'h1234_5678_0000_0000);
    step();
    drive64(2'd3, 32'h04, 64'h1);
    step();
    st_valid64 = 1'b0;
    check_eq("w64_mis_exc", 64'(st_exc64), 64'd1);
    check_eq("w64_mis_m_valid", 64'(m_valid64), 64'd0);
    check_eq("w64_mis_count", 64'(count64), 64'd0);
    step();
    check_eq("w64_mis_exc_cleared", 64'(st_exc64), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
